// File: rtl/mdr_pkg.sv
// mdr_pkg: shared constants and types for the MDR result BCD formatter
package mdr_pkg;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  typedef enum logic [1:0] {IDLE, CONV_RES, CONV_REM, DONE} bcd_state_t;
endpackage

// File: rtl/bcd_serial_conv.sv
// bcd_serial_conv: serial double-dabble engine, one binary bit per enabled cycle
module bcd_serial_conv
  import mdr_pkg::*;
#(
  parameter int DW = 16,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [DW-1:0]       bin_in,
  output logic [4*DIGITS-1:0] bcd_nxt,
  output logic                fin
);
  localparam int CW = $clog2(DW + 1);
  logic [DW-1:0] bin;
  logic [4*DIGITS-1:0] bcd, adj;
  logic [CW-1:0] cnt;
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = bcd[4*d+:4] >= 4'd5 ? bcd[4*d+:4] + 4'd3 : bcd[4*d+:4];
  end
  assign bcd_nxt = {adj[4*DIGITS-2:0], bin[DW-1]};
  assign fin = en & (cnt == CW'(DW - 1));
  always_ff @(posedge clk)
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load) begin
      bin <= bin_in;
      bcd <= '0;
      cnt <= '0;
    end else if (en) begin
      bin <= {bin[DW-2:0], 1'b0};
      bcd <= bcd_nxt;
      cnt <= fin ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/mdr_result_bcd.sv
// mdr_result_bcd: converts MDR Result/Reminder to sign + packed BCD display words
module mdr_result_bcd
  import mdr_pkg::*;
#(
  parameter int DW = 16,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready_in,
  input  logic                error_in,
  input  logic [DW-1:0]       result_in,
  input  logic [DW-1:0]       reminder_in,
  output logic [4*DIGITS-1:0] res_bcd,
  output logic                res_neg,
  output logic [4*DIGITS-1:0] rem_bcd,
  output logic                rem_neg,
  output logic                err_out,
  output logic                busy,
  output logic                done
);
  localparam int BW = 4 * DIGITS;
  bcd_state_t state, nxt;
  logic ready_q, pending, hold_err, err_flag, res_neg_s, rem_neg_s;
  logic [DW-1:0] hold_res, hold_rem, rem_cap, bin_in;
  logic [BW-1:0] res_sh, rem_sh, bcd_nxt;
  logic start, idle_like, launch, r_err, fin, load, conv;
  logic [DW-1:0] r_res, r_rem;
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
    return v[DW-1] ? ~v + DW'(1) : v;
  endfunction
  assign start = ready_in & ~ready_q;
  assign idle_like = state == IDLE || state == DONE;
  assign r_err = pending ? hold_err : error_in;
  assign r_res = pending ? hold_res : result_in;
  assign r_rem = pending ? hold_rem : reminder_in;
  assign launch = idle_like & (pending | start);
  assign conv = state == CONV_RES || state == CONV_REM;
  assign load = (launch & ~r_err) | (state == CONV_RES & fin);
  assign bin_in = state == CONV_RES ? mag(rem_cap) : mag(r_res);
  bcd_serial_conv #(.DW(DW), .DIGITS(DIGITS)) u_conv (
    .clk(clk), .rst(rst), .load(load), .en(conv), .bin_in(bin_in),
    .bcd_nxt(bcd_nxt), .fin(fin)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = launch ? (r_err ? DONE : CONV_RES)
        : state == DONE ? IDLE
        : fin ? (state == CONV_RES ? CONV_REM : DONE)
        : state;
  always_ff @(posedge clk)
    if (rst) begin
      ready_q <= 1'b0;
      pending <= 1'b0;
      hold_err <= 1'b0;
      hold_res <= '0;
      hold_rem <= '0;
      err_flag <= 1'b0;
      rem_cap <= '0;
      res_neg_s <= 1'b0;
      rem_neg_s <= 1'b0;
      res_sh <= '0;
      rem_sh <= '0;
      res_bcd <= '0;
      rem_bcd <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      err_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      ready_q <= ready_in;
      done <= state == DONE;
      if (launch) begin
        err_flag <= r_err;
        rem_cap <= r_rem;
        res_neg_s <= ~r_err & r_res[DW-1];
        rem_neg_s <= ~r_err & r_rem[DW-1];
        busy <= 1'b1;
      end else if (state == DONE) busy <= 1'b0;
      if (start & (~idle_like | pending)) begin
        pending <= 1'b1;
        hold_err <= error_in;
        hold_res <= result_in;
        hold_rem <= reminder_in;
      end else if (launch) pending <= 1'b0;
      if (state == CONV_RES & fin) res_sh <= bcd_nxt;
      if (state == CONV_REM & fin) rem_sh <= bcd_nxt;
      if (state == DONE) begin
        res_bcd <= err_flag ? {DIGITS{BLANK_DIGIT}} : res_sh;
        rem_bcd <= err_flag ? {DIGITS{BLANK_DIGIT}} : rem_sh;
        res_neg <= res_neg_s;
        rem_neg <= rem_neg_s;
        err_out <= err_flag;
      end
    end
endmodule
